// File: rtl/cnn_pkg.sv
// ============================================================================
// Module : cnn_pkg
// Shared word type, streamer state encoding and index-width helper for CNN stages
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cnn_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } stream_state_t;

  // Index width for an n-entry dimension; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage : cnn_pkg

`default_nettype wire

// File: rtl/idx_counter3.sv
// ============================================================================
// Module : idx_counter3
// Nested filter/row/column wrapping counter with end-of-filter and end-of-bank flags
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module idx_counter3
  import cnn_pkg::*;
#(
  parameter int DIM1 = 2,
  parameter int DIM2 = 2,
  parameter int DIM3 = 6,
  parameter int FW   = idx_w(DIM3),
  parameter int RW   = idx_w(DIM1),
  parameter int CW   = idx_w(DIM2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          advance,
  output logic [FW-1:0] f,
  output logic [RW-1:0] r,
  output logic [CW-1:0] c,
  output logic          filt_last,
  output logic          bank_last
);

  localparam logic [FW-1:0] F_MAX = FW'(DIM3 - 1);
  localparam logic [RW-1:0] R_MAX = RW'(DIM1 - 1);
  localparam logic [CW-1:0] C_MAX = CW'(DIM2 - 1);

  logic f_wrap;
  logic r_wrap;
  logic c_wrap;

  assign f_wrap    = (f == F_MAX);
  assign r_wrap    = (r == R_MAX);
  assign c_wrap    = (c == C_MAX);
  assign filt_last = r_wrap && c_wrap;
  assign bank_last = filt_last && f_wrap;

  // The filter index also wraps, so a following pass starts without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f <= '0;
      r <= '0;
      c <= '0;
    end else if (clear) begin
      f <= '0;
      r <= '0;
      c <= '0;
    end else if (advance) begin
      if (c_wrap) begin
        c <= '0;
        if (r_wrap) begin
          r <= '0;
          f <= f_wrap ? '0 : f + FW'(1);
        end else begin
          r <= r + RW'(1);
        end
      end else begin
        c <= c + CW'(1);
      end
    end
  end

endmodule : idx_counter3

`default_nettype wire

// File: rtl/filter_bank_streamer.sv
// ============================================================================
// Module : filter_bank_streamer
// Snapshots a 3D weight bank on start and replays it as a valid/ready word stream
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module filter_bank_streamer
  import cnn_pkg::*;
#(
  parameter int DIM1 = 2,
  parameter int DIM2 = 2,
  parameter int DIM3 = 6,
  parameter int FW   = idx_w(DIM3),
  parameter int RW   = idx_w(DIM1),
  parameter int CW   = idx_w(DIM2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  word_t         weights_in [DIM3][DIM1][DIM2],
  input  logic          start,
  input  logic [15:0]   passes,
  output logic          out_valid,
  input  logic          out_ready,
  output word_t         out_data,
  output logic [FW-1:0] out_f,
  output logic [RW-1:0] out_r,
  output logic [CW-1:0] out_c,
  output logic          filt_last,
  output logic          bank_last,
  output logic          busy,
  output logic          done
);

  stream_state_t state;
  stream_state_t state_next;

  word_t       snapshot [DIM3][DIM1][DIM2];
  logic [15:0] pass_target;
  logic [15:0] pass_cnt;

  logic        handshake;
  logic        last_pass;
  logic        capture;
  logic        cnt_clear;
  logic        cnt_adv;
  logic        pass_inc;
  logic        done_next;

  logic [FW-1:0] f;
  logic [RW-1:0] r;
  logic [CW-1:0] c;

  idx_counter3 #(
    .DIM1 (DIM1),
    .DIM2 (DIM2),
    .DIM3 (DIM3),
    .FW   (FW),
    .RW   (RW),
    .CW   (CW)
  ) u_idx (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (cnt_clear),
    .advance   (cnt_adv),
    .f         (f),
    .r         (r),
    .c         (c),
    .filt_last (filt_last),
    .bank_last (bank_last)
  );

  // Every output below depends on registered state only; out_ready feeds next-state logic alone.
  assign out_valid = (state == S_STREAM);
  assign busy      = (state == S_STREAM);
  assign out_data  = snapshot[f][r][c];
  assign out_f     = f;
  assign out_r     = r;
  assign out_c     = c;

  assign handshake = out_valid && out_ready;
  assign last_pass = (pass_cnt == pass_target - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    cnt_clear  = 1'b0;
    cnt_adv    = 1'b0;
    pass_inc   = 1'b0;
    done_next  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          capture    = 1'b1;
          cnt_clear  = 1'b1;
          state_next = S_STREAM;
        end
      end
      S_STREAM: begin
        if (handshake) begin
          cnt_adv = 1'b1;
          if (bank_last) begin
            if (last_pass) begin
              state_next = S_IDLE;
              done_next  = 1'b1;
            end else begin
              pass_inc = 1'b1;
            end
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_target <= '0;
      pass_cnt    <= '0;
    end else if (capture) begin
      pass_target <= (passes == 16'd0) ? 16'd1 : passes;
      pass_cnt    <= '0;
    end else if (pass_inc) begin
      pass_cnt <= pass_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIM3; i++) begin
        for (int j = 0; j < DIM1; j++) begin
          for (int k = 0; k < DIM2; k++) begin
            snapshot[i][j][k] <= '0;
          end
        end
      end
    end else if (capture) begin
      snapshot <= weights_in;
    end
  end

endmodule : filter_bank_streamer

`default_nettype wire

// File: tb/tb_filter_bank_streamer.sv
// ============================================================================
// Module : tb_filter_bank_streamer
// Directed bench with a queue-based reference model of the filter bank stream
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_filter_bank_streamer;

  localparam int D1 = 2;
  localparam int D2 = 2;
  localparam int D3 = 6;

  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  f;
    logic [0:0]  r;
    logic [0:0]  c;
    logic        fl;
    logic        bl;
    logic        lastrun;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] weights_in [D3][D1][D2];
  logic        start;
  logic [15:0] passes;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_f;
  logic [0:0]  out_r;
  logic [0:0]  out_c;
  logic        filt_last;
  logic        bank_last;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  beat_t       exp_q [$];
  bit          m_active = 1'b0;
  bit          m_done   = 1'b0;
  logic [31:0] acc_d  [$];
  logic [2:0]  acc_f  [$];
  logic [0:0]  acc_r  [$];
  logic [0:0]  acc_c  [$];
  bit          acc_fl [$];
  bit          acc_bl [$];
  int          done_cnt = 0;
  bit          ready_mode = 1'b0;

  filter_bank_streamer #(.DIM1(D1), .DIM2(D2), .DIM3(D3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .weights_in (weights_in),
    .start      (start),
    .passes     (passes),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_f      (out_f),
    .out_r      (out_r),
    .out_c      (out_c),
    .filt_last  (filt_last),
    .bank_last  (bank_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_weights(input bit dead);
    for (int f = 0; f < D3; f++)
      for (int r = 0; r < D1; r++)
        for (int c = 0; c < D2; c++)
          weights_in[f][r][c] = dead ? 32'hDEAD_BEEF : 32'h3F80_0000 + 32'(f * 16 + r * 4 + c);
  endtask

  task automatic pulse_start(input logic [15:0] p);
    start  = 1'b1;
    passes = p;
    tick();
    start  = 1'b0;
  endtask

  // Returns the number of cycles waited; an exhausted budget counts as a failure.
  task automatic wait_done(input int budget, input string nm, output int cycles);
    cycles = 0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (done === 1'b1) begin
        cycles = k + 1;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s_timeout actual=no_done required=done_within_%0d", nm, budget);
  endtask

  task automatic wait_accept(input int n, input int budget, input string nm);
    for (int k = 0; k < budget; k++) begin
      if (acc_d.size() >= n) return;
      tick();
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s_timeout actual=%0d required=%0d", nm, acc_d.size(), n);
  endtask

  // Backpressure source: either always ready or the 1,0,0,1 repeating pattern.
  initial begin
    logic [3:0] pat;
    int k;
    pat = 4'b1001;
    k = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode) begin
        out_ready = pat[3 - k];
        k = (k + 1) % 4;
      end else begin
        out_ready = 1'b1;
        k = 0;
      end
    end
  end

  // Reference model: a run is the full expected beat list; one beat leaves per accepted cycle.
  initial begin
    beat_t e;
    bit    nd;
    int    np;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        exp_q.delete();
        m_active = 1'b0;
        m_done   = 1'b0;
      end else begin
        check("valid", 64'(out_valid), 64'(m_active));
        check("busy", 64'(busy), 64'(m_active));
        check("done", 64'(done), 64'(m_done));
        if (m_active && exp_q.size() > 0) begin
          e = exp_q[0];
          check("data", 64'(out_data), 64'(e.d));
          check("f", 64'(out_f), 64'(e.f));
          check("r", 64'(out_r), 64'(e.r));
          check("c", 64'(out_c), 64'(e.c));
          check("filt_last", 64'(filt_last), 64'(e.fl));
          check("bank_last", 64'(bank_last), 64'(e.bl));
        end
        if (out_valid && out_ready) begin
          acc_d.push_back(out_data);
          acc_f.push_back(out_f);
          acc_r.push_back(out_r);
          acc_c.push_back(out_c);
          acc_fl.push_back(filt_last);
          acc_bl.push_back(bank_last);
        end
        if (done) done_cnt++;
        nd = 1'b0;
        if (m_active) begin
          if (out_ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.lastrun) begin
              m_active = 1'b0;
              nd = 1'b1;
            end
          end
        end else if (start) begin
          np = (passes == 16'd0) ? 1 : int'(passes);
          for (int p = 0; p < np; p++)
            for (int f = 0; f < D3; f++)
              for (int r = 0; r < D1; r++)
                for (int c = 0; c < D2; c++) begin
                  e.d  = weights_in[f][r][c];
                  e.f  = 3'(f);
                  e.r  = 1'(r);
                  e.c  = 1'(c);
                  e.fl = (r == D1 - 1) && (c == D2 - 1);
                  e.bl = e.fl && (f == D3 - 1);
                  e.lastrun = e.bl && (p == np - 1);
                  exp_q.push_back(e);
                end
          m_active = 1'b1;
        end
        m_done = nd;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int d0;
    int cyc;
    rst_n  = 1'b0;
    start  = 1'b0;
    passes = 16'd0;
    set_weights(1'b0);
    tick(); tick(); tick();
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single pass, always ready.
    base = acc_d.size();
    d0 = done_cnt;
    pulse_start(16'd1);
    wait_done(200, "t1", cyc);
    tick();
    check("t1_cycles", 64'(cyc), 64'd24);
    check("t1_beats", 64'(acc_d.size() - base), 64'd24);
    check("t1_first", 64'(acc_d[base]), 64'h3F80_0000);
    check("t1_last", 64'(acc_d[base + 23]), 64'h3F80_0055);
    for (int i = 0; i < 24; i++) begin
      check("t1_fl", 64'(acc_fl[base + i]), 64'((i % 4) == 3));
      check("t1_bl", 64'(acc_bl[base + i]), 64'(i == 23));
    end
    check("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("t1_busy_after", 64'(busy), 64'd0);

    // Backpressure 1,0,0,1.
    ready_mode = 1'b1;
    base = acc_d.size();
    d0 = done_cnt;
    pulse_start(16'd1);
    wait_done(400, "t2", cyc);
    tick();
    ready_mode = 1'b0;
    check("t2_beats", 64'(acc_d.size() - base), 64'd24);
    check("t2_beat9", 64'(acc_d[base + 9]), 64'h3F80_0021);
    check("t2_done_cnt", 64'(done_cnt - d0), 64'd1);
    tick();

    // Three passes, no bubbles at pass boundaries.
    base = acc_d.size();
    d0 = done_cnt;
    pulse_start(16'd3);
    wait_done(300, "t3", cyc);
    tick();
    check("t3_cycles", 64'(cyc), 64'd72);
    check("t3_beats", 64'(acc_d.size() - base), 64'd72);
    for (int i = 0; i < 72; i++)
      check("t3_bl", 64'(acc_bl[base + i]), 64'((i % 24) == 23));
    check("t3_done_cnt", 64'(done_cnt - d0), 64'd1);

    // Snapshot isolation and start ignored mid-stream.
    base = acc_d.size();
    d0 = done_cnt;
    pulse_start(16'd1);
    wait_accept(base + 5, 50, "t4");
    set_weights(1'b1);
    pulse_start(16'd1);
    wait_done(200, "t4", cyc);
    tick();
    check("t4_beats", 64'(acc_d.size() - base), 64'd24);
    check("t4_beat5", 64'(acc_d[base + 5]), 64'h3F80_0011);
    check("t4_last", 64'(acc_d[base + 23]), 64'h3F80_0055);
    check("t4_done_cnt", 64'(done_cnt - d0), 64'd1);
    base = acc_d.size();
    pulse_start(16'd1);
    wait_done(200, "t4b", cyc);
    tick();
    check("t4b_first", 64'(acc_d[base]), 64'hDEAD_BEEF);
    check("t4b_beats", 64'(acc_d.size() - base), 64'd24);

    // Asynchronous reset mid-stream.
    set_weights(1'b0);
    base = acc_d.size();
    pulse_start(16'd1);
    wait_accept(base + 10, 50, "t5");
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", 64'(out_valid), 64'd0);
    check("t5_async_busy", 64'(busy), 64'd0);
    check("t5_async_done", 64'(done), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("t5_idle_valid", 64'(out_valid), 64'd0);
    base = acc_d.size();
    pulse_start(16'd1);
    check("t5_restart_f", 64'(out_f), 64'd0);
    check("t5_restart_data", 64'(out_data), 64'h3F80_0000);
    wait_done(200, "t5", cyc);
    tick();
    check("t5_first_frc", 64'({acc_f[base], acc_r[base], acc_c[base]}), 64'd0);
    check("t5_beats", 64'(acc_d.size() - base), 64'd24);

    // passes=0 acts as one pass; start on the done cycle launches the next run.
    base = acc_d.size();
    d0 = done_cnt;
    pulse_start(16'd0);
    wait_done(200, "t6", cyc);
    check("t6_cycles", 64'(cyc), 64'd24);
    pulse_start(16'd0);
    check("t6_b2b_valid", 64'(out_valid), 64'd1);
    wait_done(200, "t6b", cyc);
    tick();
    check("t6_beats", 64'(acc_d.size() - base), 64'd48);
    check("t6_done_cnt", 64'(done_cnt - d0), 64'd2);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_filter_bank_streamer

`default_nettype wire
